// File: rtl/bit_serial_addsub_ctrl_pkg.sv
// rtl/bit_serial_addsub_ctrl_pkg.sv - shared FSM state and op encoding for the bit-serial add/sub block
package bit_serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bit_serial_addsub_ctrl_full_adder_subtractor.sv
// rtl/bit_serial_addsub_ctrl_full_adder_subtractor.sv - 1-bit full adder / full subtractor cell
module full_adder_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic cbin_i,
    input  logic sub_i,
    output logic s_o,
    output logic cb_o
);

    logic axb;

    assign axb  = a_i ^ b_i;
    assign s_o  = axb ^ cbin_i;
    // add: carry = ab | (a^b)cin ; sub: borrow = ~a b | ~(a^b) bin
    assign cb_o = sub_i ? ((~a_i & b_i) | (~axb & cbin_i))
                        : ((a_i & b_i) | (axb & cbin_i));

endmodule

// File: rtl/bit_serial_addsub_ctrl.sv
// rtl/bit_serial_addsub_ctrl.sv - LSB-first bit-serial add/sub controller with valid/ready handshakes
// Optional saturation on signed overflow: define BIT_SERIAL_ADDSUB_SAT_EN.
module bit_serial_addsub_ctrl
    import bit_serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cb_out,
    output logic             ovf
);

    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             op_q, cb_q;
    logic             in_ready_q, out_valid_q, cb_out_q, ovf_q;

    logic             cell_s, cell_cb, last;
    logic [WIDTH-1:0] res_d, fin_d;
    logic             ovf_d;

    full_adder_subtractor u_cell (
        .a_i    (a_q[cnt_q]),
        .b_i    (b_q[cnt_q]),
        .cbin_i (cb_q),
        .sub_i  (op_q),
        .s_o    (cell_s),
        .cb_o   (cell_cb)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));

    // ovf_d and fin_d are only meaningful on the last BUSY cycle, when res_d is complete
    always_comb begin
        res_d        = res_q;
        res_d[cnt_q] = cell_s;
        if (op_q == OP_ADD) begin
            ovf_d = (a_q[MSB] == b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
        end else begin
            ovf_d = (a_q[MSB] != b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
        end
        fin_d = res_d;
`ifdef BIT_SERIAL_ADDSUB_SAT_EN
        if (ovf_d) begin
            fin_d = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            cb_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            res_q       <= '0;
            cb_out_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        op_q       <= op;
                        cb_q       <= 1'b0;
                        cnt_q      <= '0;
                        res_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    cb_q  <= cell_cb;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        res_q       <= fin_d;
                        cb_out_q    <= cell_cb;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        res_q <= res_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign cb_out    = cb_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// tb/tb_bit_serial_addsub_ctrl.sv - scoreboard bench for bit_serial_addsub_ctrl (WIDTH=8)
module tb_bit_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cb;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             op = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             cb_out;
    logic             ovf;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    bit_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cb_out    (cb_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        logic [WIDTH:0] w;
        w = o ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        e.res = w[WIDTH-1:0];
        e.cb  = w[WIDTH];
        e.ovf = o ? ((x[WIDTH-1] != y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]))
                  : ((x[WIDTH-1] == y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]));
`ifdef BIT_SERIAL_ADDSUB_SAT_EN
        if (e.ovf) e.res = x[WIDTH-1] ? 8'h80 : 8'h7F;
`endif
        return e;
    endfunction

    // Drive one accept cycle, push the expectation, scramble inputs during BUSY.
    task automatic start_op(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit push);
        check("in_ready_before_accept", in_ready, 1'b1);
        op = o; a = x; b = y; in_valid = 1'b1;
        if (push) exp_q.push_back(model(o, x, y));
        tick();
        in_valid = 1'b0;
        op = ~o; a = ~x; b = $urandom;
    endtask

    task automatic wait_and_check(input string tag);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, WIDTH + 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_cb_out"}, cb_out, e.cb);
            check({tag, "_ovf"}, ovf, e.ovf);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_cb_out", cb_out, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        tick();

        start_op(1'b0, 8'h05, 8'h03, 1'b1);
        wait_and_check("add_small");
        check("add_small_res_const", result, 8'h08);
        tick();
        start_op(1'b0, 8'h7F, 8'h01, 1'b1);
        wait_and_check("add_ovf");
        check("add_ovf_flag_const", ovf, 1'b1);
        tick();
        start_op(1'b1, 8'h80, 8'h01, 1'b1);
        wait_and_check("sub_ovf");
        tick();
        start_op(1'b1, 8'h03, 8'h05, 1'b1);
        wait_and_check("sub_borrow");
        check("sub_borrow_res_const", result, 8'hFE);
        check("sub_borrow_cb_const", cb_out, 1'b1);
        tick();

        for (int i = 0; i < 6; i++) begin
            start_op(1'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            wait_and_check("random");
            tick();
        end

        // Backpressure: result must hold and nothing new may be accepted
        out_ready = 1'b0;
        start_op(1'b0, 8'h40, 8'h40, 1'b1);
        wait_and_check("bp");
        held = result;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = $urandom;
            b = $urandom;
            tick();
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_result_hold", result, held);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        check("bp_consumed_out_valid", out_valid, 1'b0);
        check("bp_idle_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        tick();
        check("bp_no_second_op", in_ready, 1'b1);
        check("bp_sb_empty", exp_q.size(), 0);

        // Reset while bit 4 is being processed
        start_op(1'b0, 8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_still_idle", out_valid, 1'b0);
        start_op(1'b1, 8'h10, 8'h20, 1'b1);
        wait_and_check("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
